instr_fetch_unit: RTL and testbench

// - Producer side of the instruction-word interface consumed by the Decoder.
// - Owns the PC and fetches words from instruction memory over a request/response handshake.
// - Presents one instruction at a time with a valid flag.
// - Takes dobranch/dojump back from the Decoder and redirects the PC, squashing any stale in-flight fetch.

---
 rtl/mips_pkg.sv | 17 +
 rtl/pc_next_calc.sv | 32 +++
 rtl/instr_fetch_unit.sv | 122 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction fetch slice.
//   fetch_state_t : fetch FSM encoding (FETCH / WAIT / HOLD)
//   OP_J, OP_BEQ  : opcodes of the control-transfer words the Decoder redirects on
//   WORD_BYTES    : instruction size in bytes (the sequential PC step)
package mips_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [5:0]  OP_J       = 6'b000010;
  localparam logic [5:0]  OP_BEQ     = 6'b000100;
  localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/pc_next_calc.sv
// Redirect target mux (purely combinational).
//   pcplus4  in  32 : address following the instruction being consumed
//   instr    in  26 : low 26 bits of that instruction; they hold both the
//                     jump index [25:0] and the branch immediate [15:0]
//   dobranch in   1 : take the PC-relative branch
//   dojump   in   1 : take the region jump (wins over dobranch)
//   next_pc  out 32 : next fetch address
module pc_next_calc
  import mips_pkg::*;
(
  input  logic [31:0] pcplus4,
  input  logic [25:0] instr,
  input  logic        dobranch,
  input  logic        dojump,
  output logic [31:0] next_pc
);

  logic [31:0] jmp_tgt;
  logic [31:0] br_tgt;

  // Jump stays inside the current 256 MB region of the following instruction.
  assign jmp_tgt = {pcplus4[31:28], instr[25:0], 2'b00};
  // Word offset, sign extended; the add wraps modulo 2^32.
  assign br_tgt  = pcplus4 + {{14{instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    next_pc = pcplus4;
    if (dojump)        next_pc = jmp_tgt;
    else if (dobranch) next_pc = br_tgt;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word at a time over a
// req/gnt + rvalid memory handshake and hands it to the Decoder with a valid
// flag. Decoder redirects (dobranch/dojump) are applied on the consume cycle.
//   clk, reset            : clock, async active-high reset
//   imem_req/addr/gnt     : request side, req held until gnt, addr stable
//   imem_rvalid/rdata     : one response per granted request
//   instr/instr_valid     : word presented to the Decoder
//   instr_pc/pcplus4      : its address and address+4
//   de_ready              : Decoder consumes when instr_valid is set
//   dobranch/dojump       : redirect request, only looked at on consume
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] instr_pc,
  output logic [31:0] pcplus4,
  input  logic        de_ready,
  input  logic        dobranch,
  input  logic        dojump
);

  fetch_state_t state, state_n;
  logic         armed;
  logic         kill, kill_n;
  logic [31:0]  pc, pc_n;
  logic [31:0]  instr_n, instr_pc_n, pcplus4_n;
  logic         valid_n;
  logic         consume, redirect;
  logic [31:0]  target;

  pc_next_calc u_pc_next (
    .pcplus4  (pcplus4),
    .instr    (instr[25:0]),
    .dobranch (dobranch),
    .dojump   (dojump),
    .next_pc  (target)
  );

  assign consume  = instr_valid & de_ready;
  assign redirect = consume & (dobranch | dojump);

  // armed holds the request low for the first cycle out of reset so imem_req
  // rises the cycle after reset drops; afterwards FETCH always requests.
  assign imem_req  = (state == FETCH) & armed;
  // pc only moves on rvalid (WAIT) or on consume (HOLD), so it is stable for
  // the whole time a request is pending.
  assign imem_addr = pc;

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    kill_n     = kill;
    instr_n    = instr;
    instr_pc_n = instr_pc;
    pcplus4_n  = pcplus4;
    valid_n    = instr_valid;

    if (consume) begin
      valid_n = 1'b0;
      pc_n    = target;
    end

    case (state)
      FETCH: if (imem_req && imem_gnt) state_n = WAIT;
      WAIT: begin
        if (imem_rvalid) begin
          if (kill || redirect) begin
            // Response belongs to the path that was just redirected away.
            kill_n  = 1'b0;
            state_n = FETCH;
          end else begin
            instr_n    = imem_rdata;
            instr_pc_n = pc;
            pcplus4_n  = pc + WORD_BYTES;
            pc_n       = pc + WORD_BYTES;
            valid_n    = 1'b1;
            state_n    = HOLD;
          end
        end else if (redirect) begin
          // Only a prefetching front end can consume while a fetch is in
          // flight; remember to drop its response.
          kill_n = 1'b1;
        end
      end
      HOLD: if (consume) state_n = FETCH;
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      armed       <= 1'b0;
      kill        <= 1'b0;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      instr_pc    <= '0;
      pcplus4     <= '0;
    end else begin
      state       <= state_n;
      armed       <= 1'b1;
      kill        <= kill_n;
      pc          <= pc_n;
      instr       <= instr_n;
      instr_valid <= valid_n;
      instr_pc    <= instr_pc_n;
      pcplus4     <= pcplus4_n;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  import mips_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instr, instr_pc, pcplus4;
  logic        instr_valid, de_ready, dobranch, dojump;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_pc    (instr_pc),
    .pcplus4     (pcplus4),
    .de_ready    (de_ready),
    .dobranch    (dobranch),
    .dojump      (dojump)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Architectural next-PC rule written as plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                             input logic br, input logic jp);
    logic [31:0] seq;
    int          off;
    seq = pc + 32'd4;
    off = int'($signed(ins[15:0]));
    if (jp) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    if (br) return seq + 32'(off * 4);
    return seq;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req"},   {31'd0, imem_req},    32'd0);
    chk({tag, "_addr"},  imem_addr,            RST_PC);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_instr"}, instr,                32'd0);
    chk({tag, "_ipc"},   instr_pc,             32'd0);
    chk({tag, "_pc4"},   pcplus4,              32'd0);
  endtask

  task automatic wait_req();
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", {31'd0, imem_req}, 32'd1);
  endtask

  // Answer one fetch at exp_pc: gnt after gd cycles, rvalid rd cycles later.
  task automatic serve(input logic [31:0] data, input int gd, input int rd);
    wait_req();
    chk("req_addr", imem_addr, exp_pc);
    for (int i = 0; i < gd; i++) begin
      @(negedge clk);
      chk("req_hold", {31'd0, imem_req}, 32'd1);
      chk("addr_hold", imem_addr, exp_pc);
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    chk("req_drop", {31'd0, imem_req}, 32'd0);
    for (int i = 1; i < rd; i++) begin
      imem_rdata = $urandom;
      @(negedge clk);
      chk("wait_valid", {31'd0, instr_valid}, 32'd0);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    chk("valid", {31'd0, instr_valid}, 32'd1);
    chk("instr", instr, data);
    chk("instr_pc", instr_pc, exp_pc);
    chk("pcplus4", pcplus4, exp_pc + 32'd4);
  endtask

  // Stall for some cycles (random flags must be ignored), then consume.
  task automatic consume(input int stall, input logic br, input logic jp, input logic [31:0] ins);
    for (int i = 0; i < stall; i++) begin
      de_ready = 1'b0;
      dobranch = 1'($urandom_range(0, 1));
      dojump   = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_instr", instr, ins);
      chk("stall_pc", instr_pc, exp_pc);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
    end
    de_ready = 1'b1;
    dobranch = br;
    dojump   = jp;
    @(negedge clk);
    de_ready = 1'b0;
    dobranch = 1'($urandom_range(0, 1));
    dojump   = 1'($urandom_range(0, 1));
    chk("consumed_valid", {31'd0, instr_valid}, 32'd0);
    chk("refetch_req", {31'd0, imem_req}, 32'd1);
    exp_pc = model_next(exp_pc, ins, br, jp);
  endtask

  task automatic do_instr(input logic [31:0] data, input logic br, input logic jp,
                          input int gd, input int rd, input int stall);
    serve(data, gd, rd);
    consume(stall, br, jp, data);
  endtask

  initial begin
    logic [31:0] w;
    reset       = 1'b1;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    de_ready    = 1'b0;
    dobranch    = 1'b0;
    dojump      = 1'b0;
    exp_pc      = RST_PC;

    #12;
    check_reset_vals("rst");
    @(negedge clk);
    reset = 1'b0;
    #1 chk("req_in_release_cycle", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    chk("first_req", {31'd0, imem_req}, 32'd1);

    // Directed program walk.
    do_instr(32'h2408_0005, 1'b0, 1'b0, 0, 1, 5);   // 0x0 -> 0x4, 5-cycle stall
    do_instr(32'h0000_0000, 1'b0, 1'b0, 1, 2, 0);   // 0x4 -> 0x8
    w = {OP_J, 26'h000_0010};
    do_instr(w, 1'b0, 1'b1, 0, 1, 0);               // 0x8 jump -> 0x40
    w = {OP_J, 26'h000_0008};
    do_instr(w, 1'b0, 1'b1, 2, 1, 1);               // 0x40 jump -> 0x20
    w = {OP_BEQ, 10'd0, 16'hFFFF};
    do_instr(w, 1'b1, 1'b0, 0, 1, 0);               // 0x20 branch back -> 0x20
    w = {OP_BEQ, 10'd0, 16'h0003};
    do_instr(w, 1'b1, 1'b0, 0, 3, 2);               // 0x20 -> 0x30
    do_instr(32'h0800_0004, 1'b1, 1'b1, 1, 1, 0);   // both flags: jump -> 0x10
    w = {OP_J, 26'h0};
    do_instr(w, 1'b0, 1'b1, 0, 1, 0);               // 0x10 -> 0x0
    w = {OP_BEQ, 10'd0, 16'hFFFE};
    do_instr(w, 1'b1, 1'b0, 0, 1, 0);               // 0x0 -> 0xFFFFFFFC
    do_instr(32'h1234_5678, 1'b0, 1'b0, 0, 1, 0);   // 0xFFFFFFFC -> 0x0 (wrap)
    do_instr(32'h1000_0000, 1'b0, 1'b0, 0, 1, 0);   // branch word, no flag -> 0x4

    // Randomized words, flags, handshake timing and stalls.
    for (int i = 0; i < 40; i++) begin
      do_instr($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
               int'($urandom_range(0, 3)));
    end

    // Slow grant, then reset while waiting for the response.
    wait_req();
    chk("slow_addr", imem_addr, exp_pc);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("slow_addr_hold", imem_addr, exp_pc);
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_vals("rst_wait");
    @(negedge clk);
    // The response that would have arrived 2 cycles after gnt shows up now,
    // with no request outstanding; it must be ignored.
    reset       = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("late_rvalid_valid", {31'd0, instr_valid}, 32'd0);
    chk("late_rvalid_req", {31'd0, imem_req}, 32'd1);
    exp_pc = RST_PC;
    do_instr(32'h2408_0005, 1'b0, 1'b0, 0, 1, 0);
    chk("post_reset_addr", imem_addr, exp_pc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
